// File: rtl/timer_arbiter.sv
// Round-robin arbiter that shares one counter_timer among NREQ requesters as a one-shot timeout.
// Optional lost-IRQ watchdog (adds the err port) is enabled by defining TIMER_ARB_WDOG_EN.
module timer_arbiter #(
  parameter int NREQ       = 4,
  parameter int WDOG_SLACK = 16
) (
  input  logic                 clkin,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_delay,
  input  logic [NREQ-1:0]      cancel,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic                 tmr_cfg_we,
  output logic [31:0]          tmr_cfg_di,
  output logic [3:0]           tmr_dat_we,
  output logic [31:0]          tmr_dat_di,
  input  logic                 tmr_irq
`ifdef TIMER_ARB_WDOG_EN
  ,
  output logic                 err
`endif
);

  localparam int          OW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  // enable | oneshot | irq_ena, count down
  localparam logic [31:0] CFG_START = 32'h0000_000B;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, STOP} state_t;

  state_t        state, state_next;
  logic [OW-1:0] owner, ptr, pick, cand;
  logic [31:0]   delay;
  logic          cmpl, cmpl_next;
  logic [31:0]   delays [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign delays[g] = req_delay[32*g +: 32];
  end

  // Descending scan so the last hit is the first set bit after ptr (with wrap).
  always_comb begin
    pick = ptr;
    cand = ptr;
    for (int i = NREQ; i >= 1; i--) begin
      cand = OW'((int'(ptr) + i) % NREQ);
      if (req[cand]) pick = cand;
    end
  end

`ifdef TIMER_ARB_WDOG_EN
  logic [32:0] wd_cnt;
  logic        wd_err, wd_err_next, wd_expire;

  assign wd_expire = (wd_cnt + 33'd1) >= ({1'b0, delay} + 33'(WDOG_SLACK));
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_next = state;
    cmpl_next  = cmpl;
`ifdef TIMER_ARB_WDOG_EN
    wd_err_next = wd_err;
`endif
    unique case (state)
      IDLE: if (|req) state_next = LOAD;
      LOAD: begin
        state_next = RUN;
        cmpl_next  = 1'b0;
`ifdef TIMER_ARB_WDOG_EN
        wd_err_next = 1'b0;
`endif
      end
      RUN: begin
        if (tmr_irq) begin
          state_next = STOP;
          cmpl_next  = 1'b1;
        end else if (cancel[owner]) begin
          state_next = STOP;
        end
`ifdef TIMER_ARB_WDOG_EN
        else if (wd_expire) begin
          state_next  = STOP;
          wd_err_next = 1'b1;
        end
`endif
      end
      STOP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= OW'(NREQ - 1);
      delay <= '0;
      cmpl  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      cmpl  <= cmpl_next;
      if (state == IDLE && |req) begin
        owner <= pick;
        ptr   <= pick;
        delay <= delays[pick];
      end
    end
  end

`ifdef TIMER_ARB_WDOG_EN
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      wd_err <= wd_err_next;
      if (state == LOAD)     wd_cnt <= '0;
      else if (state == RUN) wd_cnt <= wd_cnt + 33'd1;
    end
  end

  assign err = (state == STOP) && wd_err;
`endif

  // Outputs decode only from registers, so async reset clears them without a clock edge.
  always_comb begin
    gnt        = '0;
    done       = '0;
    busy       = (state != IDLE);
    tmr_cfg_we = 1'b0;
    tmr_cfg_di = '0;
    tmr_dat_we = '0;
    tmr_dat_di = '0;
    if (state != IDLE) gnt[owner] = 1'b1;
    case (state)
      LOAD: begin
        tmr_dat_we = 4'hF;
        tmr_dat_di = delay;
        tmr_cfg_we = 1'b1;
        tmr_cfg_di = CFG_START;
      end
      STOP: begin
        tmr_cfg_we = 1'b1;
        tmr_cfg_di = '0;
        if (cmpl) done[owner] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
